// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave byte engine.
package i2c_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    IGNORE
  } state_t;

  localparam int BIT_CNT_W    = 4;
  localparam int FILTER_DEPTH = 3;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer for one I2C line with edge strobes.
// Optional 3-sample majority filter when I2C_SLAVE_GLITCH_FILTER_EN is defined.
module i2c_line_filter
  import i2c_slave_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Idle I2C lines are high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[0], line};
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [FILTER_DEPTH-1:0] hist_q;
  logic                    maj_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '1;
      maj_q  <= 1'b1;
    end else begin
      hist_q <= {hist_q[FILTER_DEPTH-2:0], sync_q[1]};
      maj_q  <= (hist_q[0] & hist_q[1]) | (hist_q[1] & hist_q[2]) |
                (hist_q[0] & hist_q[2]);
    end
  end

  assign level = maj_q;
`else
  assign level = sync_q[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= level;
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/i2c_slave_base.sv
// Generic I2C slave byte engine: START/STOP detect, 7-bit address match, byte shift, ACK slots.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add majority filtering on SCL/SDA.
module i2c_slave_base
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] ADDRESS = 7'h48
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       SCL,
  inout  wire        SDA,
  output logic       START,
  output logic       STOP,
  output logic       SEL,
  output logic       RD,
  input  logic       ACK,
  output logic       ACKO,
  input  logic [7:0] DI,
  output logic [7:0] DO
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter u_scl_filter (
    .clk   (clk_i),
    .rst   (rst_i),
    .line  (SCL),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_filter u_sda_filter (
    .clk   (clk_i),
    .rst   (rst_i),
    .line  (SDA),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  state_t               state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]           shreg_q, shreg_d;
  logic [7:0]           do_q, do_d;
  logic                 rd_q, rd_d;
  logic                 acko_q, acko_d;
  logic                 start_q, start_d;
  logic                 stop_q, stop_d;
  logic                 start_det, stop_det;
  logic                 sda_drive_low;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      do_q      <= '0;
      rd_q      <= 1'b0;
      acko_q    <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      do_q      <= do_d;
      rd_q      <= rd_d;
      acko_q    <= acko_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    do_d      = do_q;
    rd_d      = rd_q;
    acko_d    = acko_q;
    start_d   = 1'b0;
    stop_d    = 1'b0;

    if (start_det) begin
      start_d   = 1'b1;
      state_d   = ADDR;
      bit_cnt_d = '0;
    end else if (stop_det) begin
      stop_d  = 1'b1;
      state_d = IDLE;
      rd_d    = 1'b0;
    end else begin
      unique case (state_q)
        ADDR, WRITE: begin
          if (scl_rise) begin
            shreg_d   = {shreg_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (state_q == WRITE && bit_cnt_q == BIT_CNT_W'(7))
              do_d = {shreg_q[6:0], sda_lvl};
          end else if (scl_fall && bit_cnt_q == BIT_CNT_W'(8)) begin
            // The ACK slot opens on the fall after the 8th bit, not on its rise.
            bit_cnt_d = '0;
            if (state_q == WRITE) begin
              state_d = WRITE_ACK;
            end else if (shreg_q[7:1] == ADDRESS) begin
              rd_d    = shreg_q[0];
              state_d = ADDR_ACK;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ACK) begin
              state_d = IGNORE;
            end else if (rd_q) begin
              shreg_d = DI;
              state_d = READ;
            end else begin
              state_d = WRITE;
            end
          end
        end
        WRITE_ACK: begin
          if (scl_fall) state_d = ACK ? WRITE : IGNORE;
        end
        READ: begin
          if (scl_fall) begin
            if (bit_cnt_q == BIT_CNT_W'(7)) begin
              bit_cnt_d = '0;
              state_d   = READ_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              shreg_d   = {shreg_q[6:0], 1'b0};
            end
          end
        end
        READ_ACK: begin
          if (scl_rise) begin
            acko_d = ~sda_lvl;
          end else if (scl_fall) begin
            if (acko_q) begin
              shreg_d = DI;
              state_d = READ;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Decoded from registered state so reset releases the bus without waiting for a clock.
  assign sda_drive_low = ((state_q == ADDR_ACK || state_q == WRITE_ACK) && ACK) ||
                         (state_q == READ && !shreg_q[7]);

  assign SDA   = sda_drive_low ? 1'b0 : 1'bz;
  assign SEL   = (state_q == ADDR_ACK) || (state_q == WRITE_ACK) || (state_q == READ_ACK);
  assign RD    = rd_q;
  assign ACKO  = acko_q;
  assign DO    = do_q;
  assign START = start_q;
  assign STOP  = stop_q;

endmodule

// File: tb/tb_i2c_slave_base.sv
// Directed bench for i2c_slave_base acting as an I2C master on a pulled-up SDA line.
module tb_i2c_slave_base;

  localparam int Q = 80;  // quarter SCL period (8 clk)

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       ack_allow = 1'b1;
  logic [7:0] di = 8'h00;
  logic       start_p, stop_p, sel, rd, acko, ack;
  logic [7:0] do_b;
  wire        sda;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int stop_cnt = 0;
  int slave_low_cnt = 0;

  pullup (sda);
  assign sda = sda_m ? 1'bz : 1'b0;
  assign ack = sel & ack_allow;

  always #5 clk = ~clk;

  i2c_slave_base #(.ADDRESS(7'h48)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .SCL   (scl_m),
    .SDA   (sda),
    .START (start_p),
    .STOP  (stop_p),
    .SEL   (sel),
    .RD    (rd),
    .ACK   (ack),
    .ACKO  (acko),
    .DI    (di),
    .DO    (do_b)
  );

  always @(posedge clk) begin
    if (start_p) start_cnt <= start_cnt + 1;
    if (stop_p) stop_cnt <= stop_cnt + 1;
    if (sda_m && sda === 1'b0) slave_low_cnt <= slave_low_cnt + 1;
  end

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
  endtask

  // ackbit is the bus level in the 9th slot (0 = slave ACK).
  task automatic write_byte(input logic [7:0] b, output logic ackbit, output logic sel_s,
                            output logic [7:0] do_s, output logic rd_s);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    ackbit = sda; sel_s = sel; do_s = do_b; rd_s = rd;
    #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b, output logic sel_s,
                           output logic acko_s);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      b[i] = sda;
      #Q;
      scl_m = 1'b0; #Q;
    end
    sda_m = ~mack; #Q;
    scl_m = 1'b1; #Q;
    sel_s = sel; acko_s = acko;
    #Q;
    scl_m = 1'b0; #Q;
    sda_m = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL reset_sel got %b exp 0", sel); end
    total++; if (rd !== 1'b0) begin bad++; $display("FAIL reset_rd got %b exp 0", rd); end
    total++; if (acko !== 1'b0) begin bad++; $display("FAIL reset_acko got %b exp 0", acko); end
    total++; if (do_b !== 8'h00) begin bad++; $display("FAIL reset_do got %h exp 00", do_b); end
    total++; if (start_p !== 1'b0) begin bad++; $display("FAIL reset_start got %b exp 0", start_p); end
    total++; if (stop_p !== 1'b0) begin bad++; $display("FAIL reset_stop got %b exp 0", stop_p); end
    total++; if (sda !== 1'b1) begin bad++; $display("FAIL reset_sda got %b exp 1", sda); end
    @(negedge clk);
    rst = 1'b0;
    #Q;
  endtask

  task automatic test_write();
    logic [7:0] wdat [3];
    logic       a, s, r;
    logic [7:0] d;
    int         st0, sp0;
    wdat = '{8'h01, 8'h60, 8'hA0};
    st0 = start_cnt; sp0 = stop_cnt;
    i2c_start();
    write_byte(8'h90, a, s, d, r);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL wr_addr_ack got %b exp 0", a); end
    total++; if (s !== 1'b1) begin bad++; $display("FAIL wr_addr_sel got %b exp 1", s); end
    total++; if (r !== 1'b0) begin bad++; $display("FAIL wr_rd got %b exp 0", r); end
    for (int i = 0; i < 3; i++) begin
      write_byte(wdat[i], a, s, d, r);
      total++; if (a !== 1'b0) begin bad++; $display("FAIL wr_data_ack[%0d] got %b exp 0", i, a); end
      total++; if (s !== 1'b1) begin bad++; $display("FAIL wr_data_sel[%0d] got %b exp 1", i, s); end
      total++; if (d !== wdat[i]) begin bad++; $display("FAIL wr_do[%0d] got %h exp %h", i, d, wdat[i]); end
    end
    i2c_stop();
    #Q;
    total++; if (start_cnt - st0 !== 1) begin bad++; $display("FAIL wr_start_cnt got %0d exp 1", start_cnt - st0); end
    total++; if (stop_cnt - sp0 !== 1) begin bad++; $display("FAIL wr_stop_cnt got %0d exp 1", stop_cnt - sp0); end
    total++; if (rd !== 1'b0) begin bad++; $display("FAIL wr_rd_after_stop got %b exp 0", rd); end
  endtask

  task automatic test_mismatch();
    logic       a, s, r;
    logic [7:0] d;
    int         st0, sp0, lo0;
    st0 = start_cnt; sp0 = stop_cnt; lo0 = slave_low_cnt;
    i2c_start();
    write_byte(8'h92, a, s, d, r);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL mm_nack got %b exp 1", a); end
    total++; if (s !== 1'b0) begin bad++; $display("FAIL mm_sel got %b exp 0", s); end
    i2c_stop();
    #Q;
    total++; if (slave_low_cnt - lo0 !== 0) begin bad++; $display("FAIL mm_sda_driven got %0d exp 0", slave_low_cnt - lo0); end
    total++; if (start_cnt - st0 !== 1) begin bad++; $display("FAIL mm_start_cnt got %0d exp 1", start_cnt - st0); end
    total++; if (stop_cnt - sp0 !== 1) begin bad++; $display("FAIL mm_stop_cnt got %0d exp 1", stop_cnt - sp0); end
  endtask

  task automatic test_read();
    logic       a, s, r, ao;
    logic [7:0] d, b;
    int         st0;
    st0 = start_cnt;
    i2c_start();
    write_byte(8'h90, a, s, d, r);
    write_byte(8'h00, a, s, d, r);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL rd_ptr_do got %h exp 00", d); end
    di = 8'h19;
    i2c_start();
    write_byte(8'h91, a, s, d, r);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL rd_addr_ack got %b exp 0", a); end
    total++; if (r !== 1'b1) begin bad++; $display("FAIL rd_rd got %b exp 1", r); end
    di = 8'h80;
    read_byte(1'b1, b, s, ao);
    total++; if (b !== 8'h19) begin bad++; $display("FAIL rd_byte0 got %h exp 19", b); end
    total++; if (s !== 1'b1) begin bad++; $display("FAIL rd_sel0 got %b exp 1", s); end
    total++; if (ao !== 1'b1) begin bad++; $display("FAIL rd_acko0 got %b exp 1", ao); end
    di = 8'h33;
    read_byte(1'b0, b, s, ao);
    total++; if (b !== 8'h80) begin bad++; $display("FAIL rd_byte1 got %h exp 80", b); end
    total++; if (s !== 1'b1) begin bad++; $display("FAIL rd_sel1 got %b exp 1", s); end
    total++; if (ao !== 1'b0) begin bad++; $display("FAIL rd_acko1 got %b exp 0", ao); end
    #Q;
    total++; if (sda !== 1'b1) begin bad++; $display("FAIL rd_release got %b exp 1", sda); end
    i2c_stop();
    #Q;
    total++; if (start_cnt - st0 !== 2) begin bad++; $display("FAIL rd_start_cnt got %0d exp 2", start_cnt - st0); end
  endtask

  task automatic test_nack_write();
    logic       a, s, r;
    logic [7:0] d;
    i2c_start();
    write_byte(8'h90, a, s, d, r);
    ack_allow = 1'b0;
    write_byte(8'h55, a, s, d, r);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL nk_sda got %b exp 1", a); end
    total++; if (s !== 1'b1) begin bad++; $display("FAIL nk_sel got %b exp 1", s); end
    total++; if (d !== 8'h55) begin bad++; $display("FAIL nk_do got %h exp 55", d); end
    ack_allow = 1'b1;
    write_byte(8'h66, a, s, d, r);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL nk_ignored_ack got %b exp 1", a); end
    total++; if (s !== 1'b0) begin bad++; $display("FAIL nk_ignored_sel got %b exp 0", s); end
    total++; if (d !== 8'h55) begin bad++; $display("FAIL nk_ignored_do got %h exp 55", d); end
    i2c_stop();
    #Q;
  endtask

  task automatic test_reset_mid();
    logic       a, s, r;
    logic [7:0] d;
    di = 8'h00;
    i2c_start();
    write_byte(8'h91, a, s, d, r);
    total++; if (sda !== 1'b0) begin bad++; $display("FAIL rm_driving got %b exp 0", sda); end
    total++; if (rd !== 1'b1) begin bad++; $display("FAIL rm_rd_before got %b exp 1", rd); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (sda !== 1'b1) begin bad++; $display("FAIL rm_sda got %b exp 1", sda); end
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL rm_sel got %b exp 0", sel); end
    total++; if (rd !== 1'b0) begin bad++; $display("FAIL rm_rd got %b exp 0", rd); end
    total++; if (do_b !== 8'h00) begin bad++; $display("FAIL rm_do got %h exp 00", do_b); end
    total++; if (acko !== 1'b0) begin bad++; $display("FAIL rm_acko got %b exp 0", acko); end
    total++; if (start_p !== 1'b0 || stop_p !== 1'b0) begin
      bad++; $display("FAIL rm_pulses got %b%b exp 00", start_p, stop_p);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
  endtask

  task automatic test_glitch();
    int st0, exp_starts;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    exp_starts = 0;
`else
    exp_starts = 1;
`endif
    #Q;
    st0 = start_cnt;
    @(negedge clk);
    sda_m = 1'b0;
    @(negedge clk);
    sda_m = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    total++; if (start_cnt - st0 !== exp_starts) begin
      bad++; $display("FAIL glitch_start got %0d exp %0d", start_cnt - st0, exp_starts);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_nack_write();
    test_reset_mid();
    test_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
